// File: rtl/rv_wb_pkg.sv
// rv_wb_pkg -- shared constants and types for the register writeback slice.
//   REG_ADDR_W   : architectural register index width
//   NUM_REGS     : number of architectural registers (x0 hardwired to zero)
//   STARVE_LIMIT : ALU wait cycles after which the ALU is forced to win arbitration
//   wb_req_t     : writeback request record (destination, data)
//   rd_writes()  : true when a destination actually modifies the register file
package rv_wb_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int STARVE_CNT_W = 3;
  localparam int WB_DATA_W    = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0]  data;
  } wb_req_t;

  // x0 is read-only: a result aimed at it is consumed but never written.
  function automatic logic rd_writes(input logic [REG_ADDR_W-1:0] rd);
    return (rd != {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/wb_arbiter.sv
// wb_arbiter -- picks at most one of the ALU / LSU producers per cycle.
// LSU wins by default; an ALU kept waiting STARVE_LIMIT cycles wins once.
// Ports:
//   clk, rstn             : clock, synchronous active-low reset
//   alu_valid, lsu_valid  : producer requests
//   alu_grant, lsu_grant  : one-hot (or zero) grants, combinational; these are
//                           the producers' ready signals
module wb_arbiter
  import rv_wb_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic alu_grant,
  output logic lsu_grant
);

  logic [STARVE_CNT_W-1:0] starve_cnt_q;
  logic [STARVE_CNT_W-1:0] starve_cnt_d;
  logic                    starve_s;

  assign starve_s = (starve_cnt_q == STARVE_CNT_W'(STARVE_LIMIT));

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    alu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (!rstn) begin
      alu_grant = 1'b0;
      lsu_grant = 1'b0;
    end else if (alu_valid && (starve_s || !lsu_valid)) begin
      alu_grant = 1'b1;
    end else if (lsu_valid) begin
      lsu_grant = 1'b1;
    end else begin
      alu_grant = 1'b0;
      lsu_grant = 1'b0;
    end
  end

  // Starvation count: cycles the ALU has been valid but refused.
  // At the limit the ALU is always granted, so the count never passes it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!alu_valid || alu_grant) begin
      starve_cnt_d = {STARVE_CNT_W{1'b0}};
    end else begin
      starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      starve_cnt_q <= {STARVE_CNT_W{1'b0}};
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback -- merges ALU and LSU results into one register-file write
// port with one cycle of registered latency, and optionally tracks pending
// writes for hazard detection.
// Build option: define RV_WB_SCOREBOARD_EN to build the pending-write
// scoreboard; otherwise o_rs1_busy/o_rs2_busy are tied to 0 and i_issue_* is
// ignored.
// Ports:
//   clk, rstn                                  : clock, sync active-low reset
//   i_alu_valid/o_alu_ready/i_alu_rd/i_alu_data : ALU result handshake
//   i_lsu_valid/o_lsu_ready/i_lsu_rd/i_lsu_data : load result handshake
//   i_issue_valid, i_issue_rd                   : newly issued destination
//   i_rs1, i_rs2 / o_rs1_busy, o_rs2_busy       : hazard query
//   o_rd, o_wen, o_wdata                        : register-file write port
module reg_writeback
  import rv_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]       i_alu_data,
  input  logic                  i_lsu_valid,
  output logic                  o_lsu_ready,
  input  logic [REG_ADDR_W-1:0] i_lsu_rd,
  input  logic [XLEN-1:0]       i_lsu_data,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic                  o_wen,
  output logic [XLEN-1:0]       o_wdata
);

  logic                  alu_grant_s;
  logic                  lsu_grant_s;
  logic                  xfer_s;
  logic [REG_ADDR_W-1:0] sel_rd_s;
  logic [XLEN-1:0]       sel_data_s;

  logic                  wen_q,   wen_d;
  logic [REG_ADDR_W-1:0] rd_q,    rd_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;

  wb_arbiter u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .alu_valid (i_alu_valid),
    .lsu_valid (i_lsu_valid),
    .alu_grant (alu_grant_s),
    .lsu_grant (lsu_grant_s)
  );

  assign o_alu_ready = alu_grant_s;
  assign o_lsu_ready = lsu_grant_s;
  assign xfer_s      = alu_grant_s | lsu_grant_s;

  // Route the granted producer's result.
  always_comb begin
    sel_rd_s   = {REG_ADDR_W{1'b0}};
    sel_data_s = {XLEN{1'b0}};
    if (lsu_grant_s) begin
      sel_rd_s   = i_lsu_rd;
      sel_data_s = i_lsu_data;
    end else if (alu_grant_s) begin
      sel_rd_s   = i_alu_rd;
      sel_data_s = i_alu_data;
    end else begin
      sel_rd_s   = {REG_ADDR_W{1'b0}};
      sel_data_s = {XLEN{1'b0}};
    end
  end

  // Next write-port state: strobe only for real writes, address/data hold
  // their last value when nothing is accepted.
  always_comb begin
    wen_d   = 1'b0;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    if (xfer_s) begin
      wen_d   = rd_writes(sel_rd_s);
      rd_d    = sel_rd_s;
      wdata_d = sel_data_s;
    end else begin
      wen_d   = 1'b0;
    end
  end

  // Write-port register stage.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wen_q   <= 1'b0;
      rd_q    <= {REG_ADDR_W{1'b0}};
      wdata_q <= {XLEN{1'b0}};
    end else begin
      wen_q   <= wen_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_wen   = wen_q;
  assign o_rd    = rd_q;
  assign o_wdata = wdata_q;

`ifdef RV_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Pending-write vector: clear on retirement, then set on issue so a new
  // producer of the same register wins; x0 is never pending.
  always_comb begin
    pending_d = pending_q;
    if (xfer_s && rd_writes(sel_rd_s)) begin
      pending_d[sel_rd_s] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (i_issue_valid && rd_writes(i_issue_rd)) begin
      pending_d[i_issue_rd] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  // Pending-write vector register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending_q <= {NUM_REGS{1'b0}};
    end else begin
      pending_q <= pending_d;
    end
  end

  assign o_rs1_busy = pending_q[i_rs1];
  assign o_rs2_busy = pending_q[i_rs2];
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{i_issue_valid, i_issue_rd, i_rs1, i_rs2};
  assign o_rs1_busy       = 1'b0;
  assign o_rs2_busy       = 1'b0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback. Inputs change 1 time unit after the
// rising edge; readies are sampled after inputs settle, registered outputs
// 1 time unit after the edge that loads them.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_alu_valid, o_alu_ready;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        i_lsu_valid, o_lsu_ready;
  logic [4:0]  i_lsu_rd;
  logic [31:0] i_lsu_data;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd, i_rs1, i_rs2;
  logic        o_rs1_busy, o_rs2_busy;
  logic [4:0]  o_rd;
  logic        o_wen;
  logic [31:0] o_wdata;

  int n_cmp = 0;
  int n_err = 0;

`ifdef RV_WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  reg_writeback #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn),
    .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
    .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready),
    .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data),
    .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
    .i_rs1(i_rs1), .i_rs2(i_rs2),
    .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
    .o_rd(o_rd), .o_wen(o_wen), .o_wdata(o_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    i_alu_valid = 1'b0; i_alu_rd = 5'd0; i_alu_data = 32'd0;
    i_lsu_valid = 1'b0; i_lsu_rd = 5'd0; i_lsu_data = 32'd0;
    i_issue_valid = 1'b0; i_issue_rd = 5'd0; i_rs1 = 5'd0; i_rs2 = 5'd0;
    tick();
    tick();
    // reset state
    chk("rst_wen",   {63'd0, o_wen},   64'd0);
    chk("rst_rd",    {59'd0, o_rd},    64'd0);
    chk("rst_wdata", {32'd0, o_wdata}, 64'd0);
    i_lsu_valid = 1'b1; i_alu_valid = 1'b1;
    #1;
    chk("rst_lsu_ready", {63'd0, o_lsu_ready}, 64'd0);
    chk("rst_alu_ready", {63'd0, o_alu_ready}, 64'd0);
    i_lsu_valid = 1'b0; i_alu_valid = 1'b0;
    rstn = 1'b1;
    tick();

    // idle: no readies without valids
    chk("idle_lsu_ready", {63'd0, o_lsu_ready}, 64'd0);
    chk("idle_alu_ready", {63'd0, o_alu_ready}, 64'd0);

    // LSU only, rd=5, 0xDEADBEEF
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd5; i_lsu_data = 32'hDEADBEEF;
    #1;
    chk("lsu_ready", {63'd0, o_lsu_ready}, 64'd1);
    chk("lsu_alu_ready", {63'd0, o_alu_ready}, 64'd0);
    tick();
    i_lsu_valid = 1'b0;
    chk("lsu_wen",   {63'd0, o_wen},   64'd1);
    chk("lsu_rd",    {59'd0, o_rd},    64'd5);
    chk("lsu_wdata", {32'd0, o_wdata}, 64'hDEADBEEF);
    tick();
    chk("idle_wen",     {63'd0, o_wen},   64'd0);
    chk("hold_rd",      {59'd0, o_rd},    64'd5);
    chk("hold_wdata",   {32'd0, o_wdata}, 64'hDEADBEEF);

    // both valid: LSU x4, ALU x1, repeating
    i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_data = 32'h0000_00A3;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd4; i_lsu_data = 32'h0000_00B4;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("arb_alu_ready_%0d", i), {63'd0, o_alu_ready}, (i % 5 == 4) ? 64'd1 : 64'd0);
      chk($sformatf("arb_lsu_ready_%0d", i), {63'd0, o_lsu_ready}, (i % 5 == 4) ? 64'd0 : 64'd1);
      tick();
      chk($sformatf("arb_rd_%0d", i), {59'd0, o_rd}, (i % 5 == 4) ? 64'd3 : 64'd4);
      chk($sformatf("arb_wdata_%0d", i), {32'd0, o_wdata}, (i % 5 == 4) ? 64'hA3 : 64'hB4);
    end
    i_lsu_valid = 1'b0;

    // ALU alone is granted immediately
    i_alu_rd = 5'd12; i_alu_data = 32'h0BAD_F00D;
    #1;
    chk("alu_only_ready", {63'd0, o_alu_ready}, 64'd1);
    tick();
    chk("alu_only_wen",   {63'd0, o_wen},   64'd1);
    chk("alu_only_wdata", {32'd0, o_wdata}, 64'h0BADF00D);

    // ALU rd=0: accepted, no write
    i_alu_rd = 5'd0; i_alu_data = 32'h0000_1234;
    #1;
    chk("x0_ready", {63'd0, o_alu_ready}, 64'd1);
    tick();
    i_alu_valid = 1'b0;
    chk("x0_wen", {63'd0, o_wen}, 64'd0);

    // scoreboard: issue rd=7
    i_issue_valid = 1'b1; i_issue_rd = 5'd7;
    tick();
    i_issue_valid = 1'b0;
    i_rs1 = 5'd7; i_rs2 = 5'd0;
    #1;
    chk("busy_after_issue", {63'd0, o_rs1_busy}, {63'd0, SB});
    chk("busy_x0",          {63'd0, o_rs2_busy}, 64'd0);
    // retire rd=7; still busy in the accepting cycle
    i_alu_valid = 1'b1; i_alu_rd = 5'd7; i_alu_data = 32'h0000_0077;
    #1;
    chk("busy_during_wb", {63'd0, o_rs1_busy}, {63'd0, SB});
    tick();
    i_alu_valid = 1'b0;
    chk("wb7_wen",  {63'd0, o_wen},  64'd1);
    chk("wb7_rd",   {59'd0, o_rd},   64'd7);
    chk("busy_cleared", {63'd0, o_rs1_busy}, 64'd0);
    // re-issue, then write and issue same register in one cycle
    i_issue_valid = 1'b1; i_issue_rd = 5'd7;
    tick();
    chk("busy_reissue", {63'd0, o_rs1_busy}, {63'd0, SB});
    i_alu_valid = 1'b1; i_alu_rd = 5'd7; i_alu_data = 32'h0000_0777;
    tick();
    i_alu_valid = 1'b0; i_issue_valid = 1'b0;
    chk("same_cycle_busy", {63'd0, o_rs1_busy}, {63'd0, SB});
    chk("same_cycle_wdata", {32'd0, o_wdata}, 64'h777);

    // issue rd=9, query on rs2
    i_issue_valid = 1'b1; i_issue_rd = 5'd9;
    tick();
    i_issue_valid = 1'b0; i_rs2 = 5'd9;
    #1;
    chk("busy_rs2_9", {63'd0, o_rs2_busy}, {63'd0, SB});

    // reset during an LSU transfer
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd9; i_lsu_data = 32'h5555_AAAA;
    rstn = 1'b0;
    #1;
    chk("rst_xfer_lsu_ready", {63'd0, o_lsu_ready}, 64'd0);
    tick();
    rstn = 1'b1; i_lsu_valid = 1'b0;
    chk("rst_xfer_wen",   {63'd0, o_wen},      64'd0);
    chk("rst_xfer_rd",    {59'd0, o_rd},       64'd0);
    chk("rst_xfer_wdata", {32'd0, o_wdata},    64'd0);
    chk("rst_busy1",      {63'd0, o_rs1_busy}, 64'd0);
    chk("rst_busy2",      {63'd0, o_rs2_busy}, 64'd0);
    tick();
    chk("post_rst_wen", {63'd0, o_wen}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width of written values.
REQ-002 The block SHALL have port clk  input  1  clock; all logic is rising-edge triggered.
REQ-003 The block SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port i_alu_valid  input  1  ALU result available.
REQ-005 The block SHALL have port o_alu_ready  output  1  ALU result accepted this cycle.
REQ-006 The block SHALL have port i_alu_rd  input  5  ALU destination register.
REQ-007 The block SHALL have port i_alu_data  input  XLEN  ALU result.
REQ-008 The block SHALL have port i_lsu_valid  input  1  load result available.
REQ-009 The block SHALL have port o_lsu_ready  output  1  load result accepted this cycle.
REQ-010 The block SHALL have port i_lsu_rd  input  5  load destination register.
REQ-011 The block SHALL have port i_lsu_data  input  XLEN  load result.
REQ-012 The block SHALL have port i_issue_valid  input  1  instruction issued with destination i_issue_rd.
REQ-013 The block SHALL have port i_issue_rd  input  5  destination of issued instruction.
REQ-014 The block SHALL have ports i_rs1, i_rs2  input  5 each  source registers queried for hazards.
REQ-015 The block SHALL have ports o_rs1_busy, o_rs2_busy  output  1 each  source has a pending write.
REQ-016 The block SHALL have ports o_rd (5), o_wen (1), o_wdata (XLEN)  output  register-file write port.

Function
REQ-017 The block SHALL accept at most one producer per cycle; a transfer occurs when valid and ready are both high.
REQ-018 ready SHALL be combinational from valids and arbitration state; ready SHALL never assert while the matching valid is low.
REQ-019 Default priority SHALL be LSU over ALU when both are valid.
REQ-020 A starvation counter SHALL increment each cycle ALU is valid but not granted; it resets to 0 on any ALU grant or when ALU is not valid.
REQ-021 When the starvation counter equals STARVE_LIMIT (4), ALU SHALL have priority for that cycle; the counter then returns to 0.
REQ-022 An accepted result in cycle N SHALL appear on o_rd/o_wdata with o_wen=1 in cycle N+1 (one-cycle registered latency).
REQ-023 With no transfer in cycle N, o_wen SHALL be 0 in cycle N+1; o_rd/o_wdata hold previous values.
REQ-024 A result with rd=0 SHALL be accepted (ready high) but SHALL produce o_wen=0.
REQ-025 The scoreboard SHALL hold a 32-bit pending vector; bit 0 is constant 0.
REQ-026 i_issue_valid with i_issue_rd!=0 SHALL set pending[i_issue_rd] at the next edge.
REQ-027 An accepted transfer SHALL clear pending[rd] at the next edge.
REQ-028 Simultaneous set and clear of the same bit SHALL leave it set (new producer wins).
REQ-029 o_rsN_busy SHALL equal pending[i_rsN] combinationally; i_rsN=0 SHALL give 0.

Reset
REQ-030 While rstn=0 at a clock edge: o_wen=0, o_rd=0, o_wdata=0, starvation counter=0, pending vector=0.
REQ-031 While rstn=0, o_alu_ready and o_lsu_ready SHALL be 0; no transfer occurs.
REQ-032 A transfer in flight when reset asserts SHALL be discarded; o_wen is 0 in the first cycle after rstn rises.

Configuration
REQ-033 Macro RV_WB_SCOREBOARD_EN defined: scoreboard per REQ-025..029 is built.
REQ-034 Macro undefined: no pending storage; o_rs1_busy=o_rs2_busy=0 constant; i_issue_* ignored; write path unchanged.

Structure
REQ-035 Package rv_wb_pkg SHALL hold REG_ADDR_W=5, NUM_REGS=32, STARVE_LIMIT=4, and typedef wb_req_t (rd, data).
REQ-036 Arbitration and starvation counter SHALL live in sub-module wb_arbiter; register stage and scoreboard in reg_writeback.

Verification
REQ-037 LSU only: valid, rd=5, data=0xDEADBEEF at cycle 10 -> o_lsu_ready=1 at 10; o_wen=1, o_rd=5, o_wdata=0xDEADBEEF at 11.
REQ-038 Both valid continuously (ALU rd=3, LSU rd=4): LSU granted 4 cycles, ALU granted cycle 5, pattern repeats.
REQ-039 ALU rd=0 data=0x1234 -> o_alu_ready=1, next cycle o_wen=0; pending vector unchanged.
REQ-040 Issue rd=7, then i_rs1=7 -> o_rs1_busy=1; ALU write rd=7 accepted -> busy=0 next cycle; issue rd=7 same cycle as write -> busy stays 1.
REQ-041 rstn low for 1 cycle during LSU transfer -> o_wen=0 next cycle, readies 0 during reset, pending cleared, busy outputs 0.
REQ-042 Build without RV_WB_SCOREBOARD_EN; issue rd=9, i_rs2=9 -> o_rs2_busy=0; writes behave as REQ-037.
